// File: rtl/decod_coordenadas_seq_if.sv
// Coordinate-in / cell-index-out handshake bundle for decod_coordenadas_seq.
// The master side supplies coordinates and accepts results; the slave is the decoder.
interface decod_coordenadas_seq_if #(
  parameter int RW = 3,
  parameter int CW = 3,
  parameter int IW = 6
);
  logic          in_valid;
  logic          in_ready;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_index;
  logic          out_err;
  logic          out_dup;

  modport master (
    output in_valid, row, col, out_ready,
    input  in_ready, out_valid, out_index, out_err, out_dup
  );

  modport slave (
    input  in_valid, row, col, out_ready,
    output in_ready, out_valid, out_index, out_err, out_dup
  );
endinterface

// File: rtl/decod_coordenadas_seq.sv
// Sequential (row, col) -> row*COLS+col decoder with range check and shift-add multiply.
// Define REPEAT_CHECK_EN to add the fired-cell history bitmap that drives out_dup.
module decod_coordenadas_seq #(
  parameter int ROWS = 7,
  parameter int COLS = 7,
  parameter int RW   = 3,
  parameter int CW   = 3,
  parameter int IW   = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  decod_coordenadas_seq_if.slave    bus,
  output logic                      busy
);

  typedef enum logic [2:0] {IDLE, CHECK, MUL, ADD, OUT} state_t;

  localparam int            CNT_W  = $clog2(RW + 1);
  localparam logic [IW-1:0] COLS_W = IW'(COLS);

  state_t             state_q, state_d;
  logic [RW-1:0]      row_q, row_d;
  logic [CW-1:0]      col_q, col_d;
  logic [RW-1:0]      mplier_q, mplier_d;
  logic [IW-1:0]      addend_q, addend_d;
  logic [IW-1:0]      acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]      index_q, index_d;
  logic               err_q, err_d;
  logic               dup_q, dup_d;
  logic               accept;
  logic               in_range;

  assign accept   = bus.in_valid && (state_q == IDLE) && !clear;
  assign in_range = (int'(row_q) < ROWS) && (int'(col_q) < COLS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_d = CHECK;
        // Out-of-range results also pass through ADD, giving a two-cycle error latency.
        CHECK:   state_d = in_range ? MUL : ADD;
        MUL:     if (cnt_q == CNT_W'(RW - 1)) state_d = ADD;
        ADD:     state_d = OUT;
        OUT:     if (bus.out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE) && !clear;
    bus.out_valid = (state_q == OUT);
    bus.out_index = bus.out_valid ? index_q : '0;
    bus.out_err   = bus.out_valid && err_q;
    bus.out_dup   = bus.out_valid && dup_q;
    busy          = (state_q != IDLE);
  end

`ifdef REPEAT_CHECK_EN
  logic [ROWS*COLS-1:0] hist_q, hist_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist_q <= '0;
    else        hist_q <= hist_d;
  end

  always_comb begin
    hist_d = hist_q;
    if (clear)
      hist_d = '0;
    else if ((state_q == OUT) && bus.out_ready && !err_q)
      hist_d[index_q] = 1'b1;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q    <= '0;
      col_q    <= '0;
      mplier_q <= '0;
      addend_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      index_q  <= '0;
      err_q    <= 1'b0;
      dup_q    <= 1'b0;
    end else begin
      row_q    <= row_d;
      col_q    <= col_d;
      mplier_q <= mplier_d;
      addend_q <= addend_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      index_q  <= index_d;
      err_q    <= err_d;
      dup_q    <= dup_d;
    end
  end

  always_comb begin
    row_d    = row_q;
    col_d    = col_q;
    mplier_d = mplier_q;
    addend_d = addend_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    index_d  = index_q;
    err_d    = err_q;
    dup_d    = dup_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          row_d = bus.row;
          col_d = bus.col;
        end
      end
      CHECK: begin
        acc_d    = '0;
        mplier_d = row_q;
        addend_d = COLS_W;
        cnt_d    = '0;
        err_d    = !in_range;
      end
      // addend tracks COLS<<k; high bits lost to the shift are never added for in-range rows.
      MUL: begin
        if (mplier_q[0]) acc_d = acc_q + addend_q;
        mplier_d = mplier_q >> 1;
        addend_d = addend_q << 1;
        cnt_d    = cnt_q + CNT_W'(1);
      end
      ADD: begin
        if (err_q) begin
          index_d = '0;
          dup_d   = 1'b0;
        end else begin
          index_d = acc_q + IW'(col_q);
`ifdef REPEAT_CHECK_EN
          dup_d   = hist_q[index_d];
`else
          dup_d   = 1'b0;
`endif
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_decod_coordenadas_seq.sv
// Directed self-checking bench for decod_coordenadas_seq at ROWS=COLS=7, RW=CW=3.
// Expected out_dup follows REPEAT_CHECK_EN as seen at compile time.
module tb_decod_coordenadas_seq;

`ifdef REPEAT_CHECK_EN
  localparam logic DUP_EN = 1'b1;
`else
  localparam logic DUP_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic clear;
  logic busy;
  int   total;
  int   bad;

  decod_coordenadas_seq_if #(.RW(3), .CW(3), .IW(6)) bus ();

  decod_coordenadas_seq #(
    .ROWS(7), .COLS(7), .RW(3), .CW(3), .IW(6)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge so outputs are sampled off the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_coord(input logic [2:0] r, input logic [2:0] c);
    bus.row      = r;
    bus.col      = c;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.out_valid, bus.out_err, bus.out_dup, busy, bus.in_ready} !== 5'b00001 || bus.out_index !== 6'd0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got v=%b e=%b d=%b busy=%b rdy=%b idx=%0d, want 0 0 0 0 1 0",
               bus.out_valid, bus.out_err, bus.out_dup, busy, bus.in_ready, bus.out_index);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_in_range();
    int lat;
    bus.out_ready = 1'b1;
    accept_coord(3'd3, 3'd4);
    wait_result(lat);
    total++;
    if (lat !== 5) begin
      bad++; $display("[TB] FAIL in_range_latency: got %0d, want 5", lat);
    end
    total++;
    if (bus.out_index !== 6'd25 || bus.out_err !== 1'b0 || bus.out_dup !== 1'b0) begin
      bad++; $display("[TB] FAIL in_range_3_4: got idx=%0d err=%b dup=%b, want 25 0 0", bus.out_index, bus.out_err, bus.out_dup);
    end
    tick();
    total++;
    if (bus.in_ready !== 1'b1 || busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL in_range_idle: got rdy=%b busy=%b v=%b, want 1 0 0", bus.in_ready, busy, bus.out_valid);
    end
  endtask

  task automatic test_out_of_range();
    int lat;
    accept_coord(3'd7, 3'd2);
    wait_result(lat);
    total++;
    if (lat !== 2) begin
      bad++; $display("[TB] FAIL oor_latency: got %0d, want 2", lat);
    end
    total++;
    if (bus.out_err !== 1'b1 || bus.out_index !== 6'd0 || bus.out_dup !== 1'b0) begin
      bad++; $display("[TB] FAIL oor_7_2: got err=%b idx=%0d dup=%b, want 1 0 0", bus.out_err, bus.out_index, bus.out_dup);
    end
    tick();
    // An error result must not have marked cell 0 as fired.
    accept_coord(3'd0, 3'd0);
    wait_result(lat);
    total++;
    if (lat !== 5 || bus.out_index !== 6'd0 || bus.out_err !== 1'b0 || bus.out_dup !== 1'b0) begin
      bad++; $display("[TB] FAIL oor_no_hist: got lat=%0d idx=%0d err=%b dup=%b, want 5 0 0 0", lat, bus.out_index, bus.out_err, bus.out_dup);
    end
    tick();
    accept_coord(3'd2, 3'd7);
    wait_result(lat);
    total++;
    if (lat !== 2 || bus.out_err !== 1'b1 || bus.out_index !== 6'd0) begin
      bad++; $display("[TB] FAIL oor_col_2_7: got lat=%0d err=%b idx=%0d, want 2 1 0", lat, bus.out_err, bus.out_index);
    end
    tick();
  endtask

  task automatic test_repeat();
    int lat;
    logic [2:0] rows [4] = '{3'd3, 3'd6, 3'd0, 3'd6};
    logic [2:0] cols [4] = '{3'd4, 3'd6, 3'd6, 3'd0};
    logic [5:0] idxs [4] = '{6'd25, 6'd48, 6'd6, 6'd42};
    logic       dups [4];
    dups = '{DUP_EN, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      accept_coord(rows[i], cols[i]);
      wait_result(lat);
      total++;
      if (lat !== 5 || bus.out_index !== idxs[i] || bus.out_err !== 1'b0 || bus.out_dup !== dups[i]) begin
        bad++;
        $display("[TB] FAIL repeat_%0d_%0d: got lat=%0d idx=%0d err=%b dup=%b, want 5 %0d 0 %b",
                 rows[i], cols[i], lat, bus.out_index, bus.out_err, bus.out_dup, idxs[i], dups[i]);
      end
      tick();
    end
    accept_coord(3'd6, 3'd6);
    wait_result(lat);
    total++;
    if (bus.out_index !== 6'd48 || bus.out_dup !== DUP_EN) begin
      bad++; $display("[TB] FAIL repeat_6_6_again: got idx=%0d dup=%b, want 48 %b", bus.out_index, bus.out_dup, DUP_EN);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int lat;
    bus.out_ready = 1'b0;
    accept_coord(3'd1, 3'd2);
    wait_result(lat);
    total++;
    if (lat !== 5 || bus.out_index !== 6'd9 || bus.out_err !== 1'b0) begin
      bad++; $display("[TB] FAIL bp_first: got lat=%0d idx=%0d err=%b, want 5 9 0", lat, bus.out_index, bus.out_err);
    end
    bus.row      = 3'd5;
    bus.col      = 3'd5;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_index !== 6'd9 || bus.out_err !== 1'b0 ||
          bus.out_dup !== 1'b0 || bus.in_ready !== 1'b0 || busy !== 1'b1) begin
        bad++;
        $display("[TB] FAIL bp_hold_%0d: got v=%b idx=%0d err=%b dup=%b rdy=%b busy=%b, want 1 9 0 0 0 1",
                 i, bus.out_valid, bus.out_index, bus.out_err, bus.out_dup, bus.in_ready, busy);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("[TB] FAIL bp_release: got v=%b rdy=%b busy=%b, want 0 1 0", bus.out_valid, bus.in_ready, busy);
    end
  endtask

  task automatic test_clear();
    int lat;
    int seen;
    accept_coord(3'd3, 3'd4);
    tick();
    tick();
    clear        = 1'b1;
    bus.row      = 3'd1;
    bus.col      = 3'd1;
    bus.in_valid = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b0) begin
      bad++; $display("[TB] FAIL clear_in_ready: got %b, want 0", bus.in_ready);
    end
    tick();
    total++;
    if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL clear_idle: got busy=%b v=%b, want 0 0", busy, bus.out_valid);
    end
    tick();
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.out_valid === 1'b1 || busy === 1'b1) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++; $display("[TB] FAIL clear_no_result: got %0d active cycles, want 0", seen);
    end
    accept_coord(3'd3, 3'd4);
    wait_result(lat);
    total++;
    if (lat !== 5 || bus.out_index !== 6'd25 || bus.out_dup !== 1'b0) begin
      bad++; $display("[TB] FAIL clear_hist_wiped: got lat=%0d idx=%0d dup=%b, want 5 25 0", lat, bus.out_index, bus.out_dup);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int lat;
    accept_coord(3'd5, 3'd5);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.out_index !== 6'd0 || bus.in_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL rst_mid_mul: got v=%b busy=%b idx=%0d rdy=%b, want 0 0 0 1", bus.out_valid, busy, bus.out_index, bus.in_ready);
    end
    #3;
    rst_n = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    accept_coord(3'd5, 3'd5);
    wait_result(lat);
    total++;
    if (lat !== 5 || bus.out_index !== 6'd40) begin
      bad++; $display("[TB] FAIL rst_pre_out: got lat=%0d idx=%0d, want 5 40", lat, bus.out_index);
    end
    tick();
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.out_index !== 6'd0 || bus.out_err !== 1'b0 ||
        bus.out_dup !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("[TB] FAIL rst_in_out: got v=%b idx=%0d err=%b dup=%b busy=%b, want all 0",
                      bus.out_valid, bus.out_index, bus.out_err, bus.out_dup, busy);
    end
    #3;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    accept_coord(3'd3, 3'd4);
    wait_result(lat);
    total++;
    if (lat !== 5 || bus.out_index !== 6'd25 || bus.out_dup !== 1'b0) begin
      bad++; $display("[TB] FAIL rst_hist_lost: got lat=%0d idx=%0d dup=%b, want 5 25 0", lat, bus.out_index, bus.out_dup);
    end
    tick();
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    rst_n         = 1'b0;
    clear         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.row       = '0;
    bus.col       = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_in_range();
    test_out_of_range();
    test_repeat();
    test_backpressure();
    test_clear();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
